step2_status_retire: RTL and testbench
======================================

// Module: step2_status_retire
// PURPOSE
// Elastic retire-side queue for the step-2 sideband status (result exponent + sign) of the FP MAC.
// Issue stage pushes {sign, exponent} when a mantissa op enters the add pipeline.
// Exit stage pops one entry per mantissa result.
// This replaces fixed-latency status delay with in-order, stall-tolerant retirement.
// Overflow and underflow are flagged as sticky errors for debug.
// PARAMETERS
// DEPTH   16  number of entries; power of two, >= 2
// EX_W    8   exponent width
// PORTS
// clock       in   1                  rising-edge clock
// resetn      in   1                  async active-low reset
// clear       in   1                  sync flush; empties queue, clears flags
// push_valid  in   1                  issue stage offers an entry
// push_ready  out  1                  queue can accept (= count != DEPTH)
// push_sign   in   1                  sign to store
// push_ex     in   EX_W               exponent to store
// pop_req     in   1                  mantissa result leaving pipeline this cycle
// pop_valid   out  1                  1-cycle pulse, pop_sign/pop_ex valid
// pop_sign    out  1                  retired sign
// pop_ex      out  EX_W               retired exponent
// count       out  $clog2(DEPTH)+1    current occupancy, 0..DEPTH
// overflow    out  1                  sticky: push_valid while !push_ready
// underflow   out  1                  sticky: pop_req while count==0
// BEHAVIOUR
// - Reset (resetn=0, async): count=0, pointers=0, pop_valid=0, pop_sign=0, pop_ex=0, overflow=0, underflow=0.
//   push_ready=1 after reset because count=0.
//   Storage array is not reset.
// - Occupancy states derive from count: EMPTY (0), ACTIVE (1..DEPTH-1), FULL (DEPTH).
// - Push is accepted iff push_valid & push_ready.
//   The entry is written at wr_ptr and wr_ptr increments mod DEPTH.
// - Pop is accepted iff pop_req & count!=0.
//   rd_ptr entry is registered to pop_sign/pop_ex, pop_valid=1 next cycle, rd_ptr increments mod DEPTH.
//   Latency is 1 cycle from pop_req to pop_valid.
// - pop_valid is 0 in any cycle following no accepted pop. pop_sign/pop_ex then hold their last value.
// - Accepted push and pop in the same cycle leave count unchanged. Ordering is strictly FIFO.
// - push_ready is computed from the registered count only.
//   When FULL, a push is refused even if a pop occurs in the same cycle (no pass-through).
// - Pop when EMPTY: underflow<=1, pop_valid stays 0, pointers unchanged.
//   A push in the same cycle is still accepted (no bypass).
// - Push when FULL: overflow<=1, entry dropped, count stays DEPTH.
// - Pointers wrap mod DEPTH. Full/empty are distinguished by count, not by pointer compare.
// - clear=1 (sync) beats push/pop in the same cycle.
//   Effects: count=0, pointers=0, pop_valid=0, overflow=0, underflow=0. pop_sign/pop_ex hold.
// - Reset asserted mid-operation discards all entries immediately. No partial state survives.
// - Flags clear only on reset or clear.
// TESTING
// T1: reset; push (1,0x85),(0,0x7F),(1,0x00); then pop_req x3
//     -> pop_valid pulses 1 cycle after each pop_req with the entries in that order; count 3->0.
// T2: push 16 entries (ex=i); push 17th
//     -> push_ready=0 at count=16, overflow=1, count=16; the 16 pops return ex 0..15.
// T3: pop_req with count=0
//     -> underflow=1, pop_valid=0, count=0; a push the same cycle gives count=1.
// T4: at count=5, push+pop every cycle for 40 cycles with ex incrementing
//     -> count stays 5, pointers wrap, pop_ex matches a FIFO reference model exactly.
// T5: count=7, assert resetn=0 mid-cycle
//     -> count=0, flags 0, pop_valid=0 without a clock edge.
//     Separately: clear+push the same cycle -> count=0.
// T6: push every cycle; pop_req = push_valid delayed 10 cycles
//     -> pop outputs equal the inputs delayed 11 cycles; count steady at 10; no flags set.

Source files
------------

// File: rtl/step2_status_retire.sv
// step2_status_retire: elastic in-order queue retiring the FP MAC step-2 {sign, exponent} status.
// Occupancy is tracked by count, so full/empty never depend on pointer comparison.
module step2_status_retire #(
    parameter int DEPTH = 16,
    parameter int EX_W  = 8
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    clear,
    input  logic                    push_valid,
    output logic                    push_ready,
    input  logic                    push_sign,
    input  logic [EX_W-1:0]         push_ex,
    input  logic                    pop_req,
    output logic                    pop_valid,
    output logic                    pop_sign,
    output logic [EX_W-1:0]         pop_ex,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {EMPTY, ACTIVE, FULL} occ_t;

    occ_t          occ;
    logic [EX_W:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push_acc, pop_acc;
    logic [AW:0]   count_nxt;

    // push_ready looks only at the registered count: no pass-through when full
    always_comb begin
        occ        = count == '0 ? EMPTY : (count == FULL_CNT ? FULL : ACTIVE);
        push_ready = occ != FULL;
        push_acc   = push_valid & push_ready;
        pop_acc    = pop_req & (occ != EMPTY);
        count_nxt  = count + (AW+1)'(push_acc) - (AW+1)'(pop_acc);
    end

    always_ff @(posedge clock)
        if (push_acc && !clear) mem[wr_ptr] <= {push_sign, push_ex};

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            pop_valid <= 1'b0;
            pop_sign  <= 1'b0;
            pop_ex    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            pop_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count     <= count_nxt;
            pop_valid <= pop_acc;
            overflow  <= overflow | (push_valid & ~push_ready);
            underflow <= underflow | (pop_req & (occ == EMPTY));
            if (push_acc) wr_ptr <= wr_ptr + AW'(1);
            if (pop_acc) begin
                rd_ptr              <= rd_ptr + AW'(1);
                {pop_sign, pop_ex}  <= mem[rd_ptr];
            end
        end
    end
endmodule

// File: tb/tb_step2_status_retire.sv
// tb_step2_status_retire: directed checks of the step-2 status retire queue.
module tb_step2_status_retire;
    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       clear = 1'b0;
    logic       push_valid = 1'b0;
    logic       push_ready;
    logic       push_sign = 1'b0;
    logic [7:0] push_ex = '0;
    logic       pop_req = 1'b0;
    logic       pop_valid;
    logic       pop_sign;
    logic [7:0] pop_ex;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int n_chk = 0;
    int n_err = 0;
    logic [8:0] q[$];
    logic [8:0] exp_e;
    logic [8:0] hist[64];

    step2_status_retire #(.DEPTH(16), .EX_W(8)) dut (
        .clock(clock), .resetn(resetn), .clear(clear),
        .push_valid(push_valid), .push_ready(push_ready),
        .push_sign(push_sign), .push_ex(push_ex),
        .pop_req(pop_req), .pop_valid(pop_valid),
        .pop_sign(pop_sign), .pop_ex(pop_ex),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic pv, input logic ps, input logic [7:0] pe, input logic pr, input logic cl);
        push_valid = pv;
        push_sign  = ps;
        push_ex    = pe;
        pop_req    = pr;
        clear      = cl;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #12;
        chk("rst_count", 32'(count), 0);
        chk("rst_ready", 32'(push_ready), 1);
        chk("rst_flags", 32'({overflow, underflow, pop_valid}), 0);
        chk("rst_pop", 32'({pop_sign, pop_ex}), 0);
        @(posedge clock);
        #1;
        resetn = 1'b1;

        // T1: three entries retire in order
        cyc(1, 1, 8'h85, 0, 0);
        cyc(1, 0, 8'h7F, 0, 0);
        cyc(1, 1, 8'h00, 0, 0);
        chk("t1_count3", 32'(count), 3);
        cyc(0, 0, 0, 1, 0);
        chk("t1_pv0", 32'(pop_valid), 1);
        chk("t1_e0", 32'({pop_sign, pop_ex}), 32'h185);
        chk("t1_cnt2", 32'(count), 2);
        cyc(0, 0, 0, 1, 0);
        chk("t1_e1", 32'({pop_valid, pop_sign, pop_ex}), 32'h27F);
        cyc(0, 0, 0, 1, 0);
        chk("t1_e2", 32'({pop_valid, pop_sign, pop_ex}), 32'h300);
        chk("t1_cnt0", 32'(count), 0);
        cyc(0, 0, 0, 0, 0);
        chk("t1_pv_drop", 32'(pop_valid), 0);
        chk("t1_hold", 32'({pop_sign, pop_ex}), 32'h100);

        // T2: fill to 16, overflow on the 17th, drain in order
        for (int i = 0; i < 16; i++) cyc(1, 1'(i & 1), 8'(i), 0, 0);
        chk("t2_full_cnt", 32'(count), 16);
        chk("t2_full_rdy", 32'(push_ready), 0);
        chk("t2_no_ovf", 32'(overflow), 0);
        cyc(1, 1, 8'hEE, 1, 0);
        chk("t2_ovf", 32'(overflow), 1);
        chk("t2_ovf_cnt", 32'(count), 15);
        chk("t2_pop0", 32'({pop_valid, pop_sign, pop_ex}), 32'h200);
        for (int i = 1; i < 16; i++) begin
            cyc(0, 0, 0, 1, 0);
            chk("t2_drain", 32'({pop_valid, pop_sign, pop_ex}), 32'h200 | 32'((i & 1) << 8) | 32'(i));
        end
        chk("t2_empty", 32'(count), 0);

        // T3: pop on empty with a simultaneous push
        cyc(1, 0, 8'h42, 1, 0);
        chk("t3_unf", 32'(underflow), 1);
        chk("t3_pv", 32'(pop_valid), 0);
        chk("t3_cnt", 32'(count), 1);
        chk("t3_ovf_sticky", 32'(overflow), 1);
        cyc(0, 0, 0, 0, 1);
        chk("t3_clear", 32'({overflow, underflow, pop_valid, count}), 0);
        chk("t3_clear_hold", 32'({pop_sign, pop_ex}), 32'h10F);

        // T4: steady push+pop at count 5 across pointer wrap
        q.delete();
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 8'(100 + i), 0, 0);
            q.push_back({1'b0, 8'(100 + i)});
        end
        for (int i = 0; i < 40; i++) begin
            cyc(1, 1'(i % 3 == 0), 8'(105 + i), 1, 0);
            q.push_back({1'(i % 3 == 0), 8'(105 + i)});
            exp_e = q.pop_front();
            chk("t4_pop", 32'({pop_valid, pop_sign, pop_ex}), 32'({1'b1, exp_e}));
            chk("t4_cnt", 32'(count), 5);
        end
        chk("t4_flags", 32'({overflow, underflow}), 0);

        // T5: async reset mid-cycle, then clear beats push
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) cyc(1, 0, 8'(i), 0, 0);
        cyc(0, 0, 0, 1, 0);
        chk("t5_pre_cnt", 32'(count), 7);
        chk("t5_pre_flags", 32'({underflow, pop_valid}), 3);
        pop_req = 1'b0;
        #3;
        resetn = 1'b0;
        #1;
        chk("t5_async", 32'({count, overflow, underflow, pop_valid}), 0);
        chk("t5_async_rdy", 32'(push_ready), 1);
        #1;
        resetn = 1'b1;
        @(posedge clock);
        #1;
        cyc(1, 0, 8'h11, 0, 0);
        cyc(1, 0, 8'h22, 0, 0);
        cyc(1, 0, 8'h33, 0, 1);
        chk("t5_clr_push", 32'(count), 0);
        cyc(0, 0, 0, 1, 0);
        chk("t5_clr_empty", 32'({pop_valid, underflow}), 1);
        cyc(0, 0, 0, 0, 1);

        // T6: pop_req trails push by 10 cycles
        for (int k = 0; k < 40; k++) begin
            hist[k] = {1'(k & 1), 8'(k * 7 + 3)};
            cyc(1, hist[k][8], hist[k][7:0], k >= 10, 0);
            if (k >= 9) chk("t6_cnt", 32'(count), 10);
            if (k >= 10) chk("t6_pop", 32'({pop_valid, pop_sign, pop_ex}), 32'({1'b1, hist[k-10]}));
        end
        chk("t6_flags", 32'({overflow, underflow}), 0);
        cyc(0, 0, 0, 0, 0);
        chk("t6_pv_off", 32'(pop_valid), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
